demo_timeline: RTL
==================

Name: demo_timeline

Overview:
- Frame-locked music/scene timeline for the VGA demo. Counts VGA frames into beats and bars.
- Drives 9 level cue lines that feed the edge decoder's `in_signals[8:0]`; the decoder turns each cue's rising edge into an event number.
- Every cue rises at a beat start and falls again after a fixed number of frames, so every scheduled cue produces exactly one rising edge.

Parameters:
- FRAMES_PER_BEAT, 30, frames per beat (120 BPM at 60 Hz); must be ≥ 2.
- HOLD_FRAMES, 2, frames a cue stays high; must satisfy 1 ≤ HOLD_FRAMES < FRAMES_PER_BEAT.
- BEATS_PER_BAR, 4, beats per bar; must be ≥ 1.
- NUM_BARS, 16, timeline length in bars; must be 1..16.
- LOOP, 1, 1 = wrap to bar 0 after the last bar; 0 = stop in DONE.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of each VGA frame
- enable  in  1  level; 1 = advance timeline, 0 = pause
- restart  in  1  synchronous one-cycle request to return to IDLE
- cue_signals  out  9  cue levels to the edge decoder
- beat_pulse  out  1  one-cycle pulse in the cycle cues are (re)asserted
- frame_in_beat  out  $clog2(FRAMES_PER_BEAT)  frame index within the current beat
- beat_num  out  $clog2(BEATS_PER_BAR) (min 1)  beat index within the current bar
- bar_num  out  4  bar index
- running  out  1  state is RUN
- done  out  1  state is DONE

Behaviour:
- Reset, and the synchronous effect of restart: state=IDLE; all counters 0; cue_signals=0; beat_pulse=0; running=0; done=0.
- Priority within a cycle: restart > enable/frame_start. A frame_start arriving in the same cycle as restart is ignored.
- All outputs are registered and update on the clk edge that samples the triggering frame_start (1-cycle latency).
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: when enable=1 and frame_start=1, go to RUN and fire bar 0, beat 0 (beat start rule below); counters = 0.
  - RUN, frame_start=1 and enable=1:
    - If frame_in_beat < FRAMES_PER_BEAT-1: frame_in_beat++.
    - Else: frame_in_beat=0 and beat_num++.
    - beat_num wraps at BEATS_PER_BAR and increments bar_num.
    - If bar_num wraps past NUM_BARS-1: LOOP=1 → bar_num=0 and the timeline keeps running; LOOP=0 → go to DONE.
    - Any wrap to frame_in_beat=0 is a beat start (except the DONE transition).
  - RUN, enable=0: go to PAUSE. Counters and cue_signals are frozen; frame_start is ignored.
  - PAUSE, enable=1: return to RUN. The next frame_start advances normally.
  - DONE: cue_signals=0; done=1; counters hold their final values. Only restart or reset leaves DONE.
- Beat start:
  - cue_signals[0]=1 (beat cue).
  - cue_signals[1]=1 only if beat_num=0 (bar cue).
  - cue_signals[8:2]=CUE_TABLE[bar_num] only if beat_num=0, otherwise 0.
  - beat_pulse=1 for exactly one clk.
- Cue drop: on the frame_start that makes the new frame_in_beat equal HOLD_FRAMES, all cue_signals clear to 0. Cues are therefore high for exactly HOLD_FRAMES frames.
- Simultaneous cues rise in the same cycle. The downstream decoder resolves them by lowest index; the timeline does no serialisation.
- Reset or restart while cues are high: cues drop immediately. This can never create a spurious rising edge.
- frame_start while in IDLE with enable=0: ignored.

Decomposition:
- Package demo_timeline_pkg holds:
  - the state enum;
  - CUE_BEAT=0 and CUE_BAR=1;
  - CUE_TABLE[0:15] of 7-bit masks for cues 8..2. Entry 0 = 7'b0000001 (cue 2); entry 1 = 7'b0000010 (cue 3); entry 2 = 7'b0000100; entry 3 = 7'b0000000; remaining entries are defined by the scene list.
- One sub-module, timeline_counter: cascaded frame/beat/bar counter with an advance input and a wrap/last-bar flag.
- Cue generation and the FSM live in the top module.

Test Plan (all runs use FRAMES_PER_BEAT=4, HOLD_FRAMES=2, BEATS_PER_BAR=4, NUM_BARS=2, frame_start every 10 clk):
- Reset, then enable=1 and first frame_start → next clk: cue_signals=9'b000000111, beat_pulse=1, running=1. Cues clear at the 2nd following frame_start. beat_num=1 with cue_signals=9'b000000001 after 4 frames.
- Run to bar 1, beat 0 → cue_signals=9'b000001011. Decoder reports event 0 (lowest-index priority).
- LOOP=0 at the end of bar 1, beat 3 → DONE, done=1, cues 0. Further frame_starts cause no change. restart → IDLE.
- LOOP=1 at the same point → bar_num=0, cues=9'b000000111, running stays 1.
- enable=0 while cues are high → PAUSE; cues stay high over 5 frame_starts. enable=1 → cues drop after the remaining hold frame.
- restart and frame_start in the same cycle mid-beat → IDLE, all outputs 0. Async reset mid-hold → cues 0 immediately.

Source files
------------

// File: rtl/demo_timeline_pkg.sv
// Shared types and scene data for the demo timeline: FSM state codes, cue line
// indices and the per-bar scene cue table.
package demo_timeline_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int CUE_BEAT = 0;
    localparam int CUE_BAR  = 1;

    // Scene cue masks for cue lines 8..2, indexed by bar number (entry 0 leftmost).
    localparam logic [0:15][6:0] CUE_TABLE = {
        7'b0000001, 7'b0000010, 7'b0000100, 7'b0000000,
        7'b0001000, 7'b0010000, 7'b0000000, 7'b0100000,
        7'b1000000, 7'b0000001, 7'b0000110, 7'b0000000,
        7'b0011000, 7'b0000000, 7'b1100000, 7'b1111111
    };

    function automatic logic [8:0] beat_cues(input logic first_beat, input logic [3:0] bar);
        logic [8:0] c;
        c           = '0;
        c[CUE_BEAT] = 1'b1;
        if (first_beat) begin
            c[CUE_BAR] = 1'b1;
            c[8:2]     = CUE_TABLE[bar];
        end
        return c;
    endfunction

endpackage

// File: rtl/demo_timeline_counter.sv
// Cascaded frame/beat/bar counter. Exposes the next values so the caller can
// derive cues for the frame being entered, plus beat-wrap and last-frame flags.
module timeline_counter #(
    parameter  int FRAMES_PER_BEAT = 30,
    parameter  int BEATS_PER_BAR   = 4,
    parameter  int NUM_BARS        = 16,
    localparam int FW              = $clog2(FRAMES_PER_BEAT),
    localparam int BW              = (BEATS_PER_BAR > 1) ? $clog2(BEATS_PER_BAR) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [FW-1:0] o_frame,
    output logic [BW-1:0] o_beat,
    output logic [3:0]    o_bar,
    output logic [FW-1:0] o_nxt_frame,
    output logic [BW-1:0] o_nxt_beat,
    output logic [3:0]    o_nxt_bar,
    output logic          o_beat_wrap,
    output logic          o_last
);

    logic [FW-1:0] r_frame;
    logic [BW-1:0] r_beat;
    logic [3:0]    r_bar;
    logic          w_frame_max;
    logic          w_beat_max;
    logic          w_bar_max;

    assign w_frame_max = (r_frame == FW'(FRAMES_PER_BEAT - 1));
    assign w_beat_max  = (r_beat == BW'(BEATS_PER_BAR - 1));
    assign w_bar_max   = (r_bar == 4'(NUM_BARS - 1));

    assign o_nxt_frame = w_frame_max ? '0 : r_frame + 1'b1;
    assign o_nxt_beat  = !w_frame_max ? r_beat : (w_beat_max ? '0 : r_beat + 1'b1);
    assign o_nxt_bar   = !(w_frame_max && w_beat_max) ? r_bar : (w_bar_max ? 4'd0 : r_bar + 4'd1);
    assign o_beat_wrap = w_frame_max;
    assign o_last      = w_frame_max && w_beat_max && w_bar_max;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame <= '0;
            r_beat  <= '0;
            r_bar   <= '0;
        end else if (i_clear) begin
            r_frame <= '0;
            r_beat  <= '0;
            r_bar   <= '0;
        end else if (i_advance) begin
            r_frame <= o_nxt_frame;
            r_beat  <= o_nxt_beat;
            r_bar   <= o_nxt_bar;
        end
    end

    assign o_frame = r_frame;
    assign o_beat  = r_beat;
    assign o_bar   = r_bar;

endmodule

// File: rtl/demo_timeline.sv
// Frame-locked demo timeline: counts VGA frames into beats and bars and raises
// level cues at beat starts that drop again after HOLD_FRAMES frames.
module demo_timeline
    import demo_timeline_pkg::*;
#(
    parameter  int FRAMES_PER_BEAT = 30,
    parameter  int HOLD_FRAMES     = 2,
    parameter  int BEATS_PER_BAR   = 4,
    parameter  int NUM_BARS        = 16,
    parameter  int LOOP            = 1,
    localparam int FW              = $clog2(FRAMES_PER_BEAT),
    localparam int BW              = (BEATS_PER_BAR > 1) ? $clog2(BEATS_PER_BAR) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          enable,
    input  logic          restart,
    output logic [8:0]    cue_signals,
    output logic          beat_pulse,
    output logic [FW-1:0] frame_in_beat,
    output logic [BW-1:0] beat_num,
    output logic [3:0]    bar_num,
    output logic          running,
    output logic          done
);

    state_t        r_state;
    logic [8:0]    r_cues;
    logic          r_pulse;

    logic [FW-1:0] w_nxt_frame;
    logic [BW-1:0] w_nxt_beat;
    logic [3:0]    w_nxt_bar;
    logic          w_beat_wrap;
    logic          w_last;
    logic          w_tick;
    logic          w_stop;
    logic          w_advance;

    assign w_tick    = frame_start && enable && (r_state == ST_RUN);
    // Without LOOP the frame after the last one ends the show and counters keep their final values.
    assign w_stop    = w_tick && w_last && (LOOP == 0);
    assign w_advance = w_tick && !restart && !w_stop;

    timeline_counter #(
        .FRAMES_PER_BEAT (FRAMES_PER_BEAT),
        .BEATS_PER_BAR   (BEATS_PER_BAR),
        .NUM_BARS        (NUM_BARS)
    ) u_counter (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_clear     (restart),
        .i_advance   (w_advance),
        .o_frame     (frame_in_beat),
        .o_beat      (beat_num),
        .o_bar       (bar_num),
        .o_nxt_frame (w_nxt_frame),
        .o_nxt_beat  (w_nxt_beat),
        .o_nxt_bar   (w_nxt_bar),
        .o_beat_wrap (w_beat_wrap),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cues  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (restart) begin
                r_state <= ST_IDLE;
                r_cues  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (enable && frame_start) begin
                            r_state <= ST_RUN;
                            r_cues  <= beat_cues(1'b1, 4'd0);
                            r_pulse <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!enable) begin
                            r_state <= ST_PAUSE;
                        end else if (frame_start) begin
                            if (w_stop) begin
                                r_state <= ST_DONE;
                                r_cues  <= '0;
                            end else if (w_beat_wrap) begin
                                r_cues  <= beat_cues(w_nxt_beat == '0, w_nxt_bar);
                                r_pulse <= 1'b1;
                            end else if (w_nxt_frame == FW'(HOLD_FRAMES)) begin
                                r_cues  <= '0;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (enable) r_state <= ST_RUN;
                    end
                    default: begin
                        r_cues <= '0;
                    end
                endcase
            end
        end
    end

    assign cue_signals = r_cues;
    assign beat_pulse  = r_pulse;
    assign running     = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);

endmodule
